// File: rtl/uirgb24to32pack_pkg.sv
// Shared constants for the 24-bit RGB to 32-bit word packer.
// Phase encoding, byte-enable patterns and the pad-lane helper live here.
package uirgb_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    localparam logic [3:0] KEEP_FULL = 4'hF;
    localparam logic [3:0] KEEP_3B   = 4'h7;
    localparam logic [3:0] KEEP_2B   = 4'h3;
    localparam logic [3:0] KEEP_1B   = 4'h1;
    localparam logic [3:0] KEEP_NONE = 4'h0;

    // Builds a partial word: lanes with keep=1 come from data, the rest get pad.
    function automatic logic [WORD_W-1:0] pad_word(input logic [PIX_W-1:0] data,
                                                   input logic [3:0]       keep,
                                                   input logic [7:0]       pad);
        logic [WORD_W-1:0] src;
        logic [WORD_W-1:0] word;
        src  = {8'h00, data};
        word = '0;
        for (int i = 0; i < 4; i++) begin
            word[8*i +: 8] = keep[i] ? src[8*i +: 8] : pad;
        end
        return word;
    endfunction

endpackage

// File: rtl/uirgb24to32pack_if.sv
// Pixel-in / word-out stream bundle for the packer.
// The slave modport is the packer itself; master is whoever drives and drains it.
interface uirgb24to32pack_if;
    import uirgb_pkg::*;

    logic              s_valid_i;
    logic              s_ready_o;
    logic [PIX_W-1:0]  s_data_i;
    logic              s_last_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [WORD_W-1:0] m_data_o;
    logic [3:0]        m_keep_o;
    logic              m_last_o;

    modport master (
        output s_valid_i, s_data_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_keep_o, m_last_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_keep_o, m_last_o
    );

endinterface

// File: rtl/uirgb24to32pack.sv
// Packs a 24-bit pixel stream into 32-bit words, four pixels per three words.
// Frame-end partial words are flushed with byte-enables through a single output register.
module uirgb24to32pack
    import uirgb_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uirgb24to32pack_if.slave   bus
);

    phase_t            phase;
    logic [PIX_W-1:0]  res;
    logic              flush_pending;
    logic [3:0]        flush_keep;

    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic [3:0]        out_keep;
    logic              out_last;

    logic              out_free;
    logic              in_ready;
    logic              accept;

    logic              emit;
    logic [WORD_W-1:0] word_next;
    logic [3:0]        keep_next;
    logic              last_next;
    logic [PIX_W-1:0]  res_next;
    phase_t            phase_next;
    logic [3:0]        flush_keep_next;

    assign out_free = !out_valid || bus.m_ready_i;
    assign in_ready = !rst_i && !flush_pending && out_free;
    assign accept   = bus.s_valid_i && in_ready;

    assign bus.s_ready_o = in_ready;
    assign bus.m_valid_o = out_valid;
    assign bus.m_data_o  = out_data;
    assign bus.m_keep_o  = out_keep;
    assign bus.m_last_o  = out_last;

    // What an accepted pixel does in the current phase; a nonzero flush_keep_next
    // means the residual must go out as a trailing partial word.
    always_comb begin
        emit            = 1'b0;
        word_next       = '0;
        keep_next       = KEEP_FULL;
        last_next       = 1'b0;
        res_next        = res;
        phase_next      = phase;
        flush_keep_next = KEEP_NONE;
        case (phase)
            PH0: begin
                if (bus.s_last_i) begin
                    emit       = 1'b1;
                    word_next  = pad_word(bus.s_data_i, KEEP_3B, PAD_BYTE);
                    keep_next  = KEEP_3B;
                    last_next  = 1'b1;
                    res_next   = '0;
                    phase_next = PH0;
                end else begin
                    res_next   = bus.s_data_i;
                    phase_next = PH1;
                end
            end
            PH1: begin
                emit       = 1'b1;
                word_next  = {bus.s_data_i[7:0], res};
                res_next   = {8'h00, bus.s_data_i[23:8]};
                phase_next = PH2;
                if (bus.s_last_i) begin
                    flush_keep_next = KEEP_2B;
                    phase_next      = PH0;
                end
            end
            PH2: begin
                emit       = 1'b1;
                word_next  = {bus.s_data_i[15:0], res[15:0]};
                res_next   = {16'h0000, bus.s_data_i[23:16]};
                phase_next = PH3;
                if (bus.s_last_i) begin
                    flush_keep_next = KEEP_1B;
                    phase_next      = PH0;
                end
            end
            PH3: begin
                emit       = 1'b1;
                word_next  = {bus.s_data_i, res[7:0]};
                last_next  = bus.s_last_i;
                res_next   = '0;
                phase_next = PH0;
            end
            default: begin
                phase_next = PH0;
            end
        endcase
    end

    // A pending flush blocks new pixels, so it and an accepted pixel never
    // compete for the output register in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase         <= PH0;
            res           <= '0;
            flush_pending <= 1'b0;
            flush_keep    <= KEEP_NONE;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_keep      <= KEEP_NONE;
            out_last      <= 1'b0;
        end else begin
            if (out_valid && bus.m_ready_i) begin
                out_valid <= 1'b0;
            end
            if (flush_pending && out_free) begin
                out_valid     <= 1'b1;
                out_data      <= pad_word(res, flush_keep, PAD_BYTE);
                out_keep      <= flush_keep;
                out_last      <= 1'b1;
                flush_pending <= 1'b0;
                flush_keep    <= KEEP_NONE;
                res           <= '0;
            end else if (accept) begin
                phase <= phase_next;
                res   <= res_next;
                if (emit) begin
                    out_valid <= 1'b1;
                    out_data  <= word_next;
                    out_keep  <= keep_next;
                    out_last  <= last_next;
                end
                if (flush_keep_next != KEEP_NONE) begin
                    flush_pending <= 1'b1;
                    flush_keep    <= flush_keep_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_uirgb24to32pack.sv
// Directed and backpressure checks for the 24-to-32 pixel packer.
// A second instance with an 0xAA pad byte shares the stimulus of the first.
module tb_uirgb24to32pack;
    import uirgb_pkg::*;

    typedef logic [36:0] rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rec_t q0[$];
    rec_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uirgb24to32pack_if bus0 ();
    uirgb24to32pack_if bus1 ();

    assign bus1.s_valid_i = bus0.s_valid_i;
    assign bus1.s_data_i  = bus0.s_data_i;
    assign bus1.s_last_i  = bus0.s_last_i;
    assign bus1.m_ready_i = bus0.m_ready_i;

    uirgb24to32pack #(.PAD_BYTE(8'h00)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0.slave)
    );

    uirgb24to32pack #(.PAD_BYTE(8'hAA)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    // Inputs only change just after a rising edge, so the falling edge sees
    // exactly the handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.m_valid_o && bus0.m_ready_i)
                q0.push_back({bus0.m_data_o, bus0.m_keep_o, bus0.m_last_o});
            if (bus1.m_valid_o && bus1.m_ready_i)
                q1.push_back({bus1.m_data_o, bus1.m_keep_o, bus1.m_last_o});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_pixel(input logic [23:0] d, input logic l);
        bit hs;
        int n;
        n = 0;
        hs = 1'b0;
        bus0.s_valid_i = 1'b1;
        bus0.s_data_i  = d;
        bus0.s_last_i  = l;
        #1;
        while (!hs && n < 200) begin
            hs = bus0.s_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bus0.s_valid_i = 1'b0;
        bus0.s_last_i  = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("[TB] FAIL pixel_accept: pixel %h not accepted within %0d cycles", d, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.m_ready_i = 1'b1;
        bus0.s_valid_i = 1'b0;
        bus0.s_data_i  = '0;
        bus0.s_last_i  = 1'b0;
        settle(3);
        checks++;
        if (bus0.s_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0", bus0.s_ready_o);
        end
        checks++;
        if (bus0.m_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus0.m_valid_o);
        end
        checks++;
        if ({bus0.m_data_o, bus0.m_keep_o, bus0.m_last_o} !== 37'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {bus0.m_data_o, bus0.m_keep_o, bus0.m_last_o});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus0.s_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", bus0.s_ready_o);
        end
    endtask

    task automatic test_four_pixel_frame();
        rec_t exp[3];
        int   start;
        exp[0] = {32'h04030201, 4'hF, 1'b0};
        exp[1] = {32'h08070605, 4'hF, 1'b0};
        exp[2] = {32'h0C0B0A09, 4'hF, 1'b1};
        q0.delete();
        start = cyc;
        drive_pixel(24'h030201, 1'b0);
        drive_pixel(24'h060504, 1'b0);
        drive_pixel(24'h090807, 1'b0);
        drive_pixel(24'h0C0B0A, 1'b1);
        checks++;
        if (cyc - start !== 4) begin
            errors++;
            $display("[TB] FAIL four_no_bubble: took %0d cycles expected 4", cyc - start);
        end
        settle(3);
        checks++;
        if (q0.size() !== 3) begin
            errors++;
            $display("[TB] FAIL four_word_count: got %0d expected 3", q0.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < q0.size()) begin
                checks++;
                if (q0[i] !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL four_word%0d: got %h expected %h", i, q0[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_single_pixel();
        rec_t exp;
        exp = {32'h00030201, 4'h7, 1'b1};
        q0.delete();
        drive_pixel(24'h030201, 1'b1);
        settle(3);
        checks++;
        if (q0.size() !== 1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d expected 1", q0.size());
        end else begin
            checks++;
            if (q0[0] !== exp) begin
                errors++;
                $display("[TB] FAIL single_word: got %h expected %h", q0[0], exp);
            end
        end
    endtask

    task automatic test_two_pixel_flush();
        rec_t exp[2];
        exp[0] = {32'h04030201, 4'hF, 1'b0};
        exp[1] = {32'h00000605, 4'h3, 1'b1};
        q0.delete();
        drive_pixel(24'h030201, 1'b0);
        drive_pixel(24'h060504, 1'b1);
        checks++;
        if (bus0.s_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stall: s_ready got %b expected 0", bus0.s_ready_o);
        end
        tick();
        checks++;
        if (bus0.s_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_stall_end: s_ready got %b expected 1", bus0.s_ready_o);
        end
        settle(3);
        checks++;
        if (q0.size() !== 2) begin
            errors++;
            $display("[TB] FAIL two_count: got %0d expected 2", q0.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < q0.size()) begin
                checks++;
                if (q0[i] !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL two_word%0d: got %h expected %h", i, q0[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_three_pixel_pad();
        rec_t exp0[3];
        rec_t exp1_last;
        exp0[0]   = {32'h04030201, 4'hF, 1'b0};
        exp0[1]   = {32'h08070605, 4'hF, 1'b0};
        exp0[2]   = {32'h00000009, 4'h1, 1'b1};
        exp1_last = {32'hAAAAAA09, 4'h1, 1'b1};
        q0.delete();
        q1.delete();
        drive_pixel(24'h030201, 1'b0);
        drive_pixel(24'h060504, 1'b0);
        drive_pixel(24'h090807, 1'b1);
        settle(4);
        checks++;
        if (q0.size() !== 3) begin
            errors++;
            $display("[TB] FAIL three_count: got %0d expected 3", q0.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < q0.size()) begin
                checks++;
                if (q0[i] !== exp0[i]) begin
                    errors++;
                    $display("[TB] FAIL three_word%0d: got %h expected %h", i, q0[i], exp0[i]);
                end
            end
        end
        checks++;
        if (q1.size() !== 3) begin
            errors++;
            $display("[TB] FAIL pad_count: got %0d expected 3", q1.size());
        end else begin
            checks++;
            if (q1[2] !== exp1_last) begin
                errors++;
                $display("[TB] FAIL pad_word: got %h expected %h", q1[2], exp1_last);
            end
        end
    endtask

    task automatic test_random_backpressure();
        int   idx;
        int   ncyc;
        int   bad;
        int   first_bad;
        int   stall_bad;
        bit   hs;
        bit   stalled;
        rec_t held;
        rec_t exp;
        idx = 0;
        ncyc = 0;
        bad = 0;
        first_bad = -1;
        stall_bad = 0;
        q0.delete();
        bus0.s_valid_i = 1'b0;
        while ((idx < 1920 || q0.size() < 1440) && ncyc < 20000) begin
            bus0.m_ready_i = ($urandom_range(0, 3) != 0);
            if (idx < 1920 && !bus0.s_valid_i) begin
                bus0.s_valid_i = ($urandom_range(0, 4) != 0);
                bus0.s_data_i  = {8'(3*idx+2), 8'(3*idx+1), 8'(3*idx)};
                bus0.s_last_i  = (idx == 1919);
            end
            #1;
            hs      = bus0.s_valid_i && bus0.s_ready_o;
            stalled = bus0.m_valid_o && !bus0.m_ready_i;
            held    = {bus0.m_data_o, bus0.m_keep_o, bus0.m_last_o};
            @(posedge clk);
            #1;
            ncyc++;
            if (hs) begin
                idx++;
                bus0.s_valid_i = 1'b0;
                bus0.s_last_i  = 1'b0;
            end
            if (stalled) begin
                if (bus0.m_valid_o !== 1'b1 ||
                    {bus0.m_data_o, bus0.m_keep_o, bus0.m_last_o} !== held)
                    stall_bad++;
            end
        end
        bus0.s_valid_i = 1'b0;
        bus0.m_ready_i = 1'b1;
        settle(4);
        checks++;
        if (idx !== 1920) begin
            errors++;
            $display("[TB] FAIL rand_pixels_accepted: got %0d expected 1920", idx);
        end
        checks++;
        if (q0.size() !== 1440) begin
            errors++;
            $display("[TB] FAIL rand_word_count: got %0d expected 1440", q0.size());
        end
        for (int k = 0; k < q0.size() && k < 1440; k++) begin
            exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k), 4'hF, (k == 1439)};
            if (q0[k] !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL rand_words: %0d wrong words, first at %0d got %h", bad, first_bad,
                     q0[first_bad]);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("[TB] FAIL rand_stall_stable: %0d unstable stall cycles, expected 0", stall_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        rec_t exp;
        exp = {32'h00030201, 4'h7, 1'b1};
        bus0.m_ready_i = 1'b1;
        drive_pixel(24'h030201, 1'b0);
        drive_pixel(24'h060504, 1'b0);
        bus0.m_ready_i = 1'b0;
        q0.delete();
        rst = 1'b1;
        #1;
        checks++;
        if (bus0.s_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_in_reset: got %b expected 0", bus0.s_ready_o);
        end
        tick();
        rst = 1'b0;
        bus0.m_ready_i = 1'b1;
        tick();
        checks++;
        if (bus0.m_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_valid_cleared: got %b expected 0", bus0.m_valid_o);
        end
        drive_pixel(24'h030201, 1'b1);
        settle(3);
        checks++;
        if (q0.size() !== 1) begin
            errors++;
            $display("[TB] FAIL midframe_count: got %0d expected 1", q0.size());
        end else begin
            checks++;
            if (q0[0] !== exp) begin
                errors++;
                $display("[TB] FAIL midframe_word: got %h expected %h", q0[0], exp);
            end
        end
    endtask

    task automatic test_reset_during_flush();
        rec_t exp;
        exp = {32'h00030201, 4'h7, 1'b1};
        bus0.m_ready_i = 1'b0;
        drive_pixel(24'h030201, 1'b0);
        drive_pixel(24'h060504, 1'b1);
        checks++;
        if (bus0.s_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_pending_ready: got %b expected 0", bus0.s_ready_o);
        end
        q0.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.m_ready_i = 1'b1;
        settle(4);
        checks++;
        if (q0.size() !== 0) begin
            errors++;
            $display("[TB] FAIL no_stale_flush: got %0d words expected 0", q0.size());
        end
        drive_pixel(24'h030201, 1'b1);
        settle(3);
        checks++;
        if (q0.size() !== 1) begin
            errors++;
            $display("[TB] FAIL postflush_count: got %0d expected 1", q0.size());
        end else begin
            checks++;
            if (q0[0] !== exp) begin
                errors++;
                $display("[TB] FAIL postflush_word: got %h expected %h", q0[0], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_four_pixel_frame();
        test_single_pixel();
        test_two_pixel_flush();
        test_three_pixel_pad();
        test_random_backpressure();
        test_reset_mid_frame();
        test_reset_during_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uirgb24to32pack.md
# uirgb24to32pack

Streaming packer that turns a 24-bit RGB pixel stream into densely packed 32-bit memory words, with 4 pixels going into 3 words and no discarded bytes. It sits on the capture-to-DDR write path, ahead of the frame-buffer write master. It is the write-side counterpart of the 32-to-24 pixel narrowing used on the read/display side. A frame end is marked by a last flag; any partial word is flushed with byte-enables.

## Interface
- PAD_BYTE, 8'h00, value placed in unused byte lanes of a flushed partial word
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- s_valid_i  input  1  input pixel valid
- s_ready_o  output  1  packer can accept a pixel this cycle
- s_data_i  input  24  pixel, {R,G,B}, bit 0 = lane-0 byte
- s_last_i  input  1  pixel is the last of the frame
- m_valid_o  output  1  output word valid
- m_ready_i  input  1  downstream accepts word
- m_data_o  output  32  packed word, little-endian byte lanes
- m_keep_o  output  4  byte enables, 1 = lane holds pixel data
- m_last_o  output  1  final word of the frame

## Operation
- Transfers occur on valid&ready; input and output follow the same rule independently.
- 2-bit phase counter 0..3 and a residual register of up to 3 bytes; the phase counter advances on each accepted pixel.
- Phase 0: store p[23:0] as residual (3 bytes); no word is emitted.
- Phase 1: emit {p[7:0],res[23:0]}; residual ← p[23:8] (2 bytes).
- Phase 2: emit {p[15:0],res[15:0]}; residual ← p[23:16] (1 byte).
- Phase 3: emit {p[23:0],res[7:0]}; residual is empty; phase ← 0.
- Words without last have keep=4'hF and m_last_o=0.
- Last pixel handling (phase returns to 0 afterwards in every case):
  - phase 0: emit a single word {PAD_BYTE,p} with keep 4'h7 and m_last_o=1.
  - phase 1: emit the normal word (keep F, not last), then a flush word {2×PAD_BYTE,p[23:8]} with keep 4'h3 and last.
  - phase 2: emit the normal word, then a flush word {3×PAD_BYTE,p[23:16]} with keep 4'h1 and last.
  - phase 3: emit the normal word with keep F and m_last_o=1; no flush.
- Flush: a one-bit flush_pending flag holds the flush word until the output register frees. s_ready_o=0 while flush_pending=1.
- Word count per frame of N pixels = ceil(3N/4).

## Timing
- Single output register; the word appears on m_data_o the cycle after the pixel that completes it is accepted.
- s_ready_o = !rst_i && !flush_pending && (!m_valid_o || m_ready_i). Combinational from m_ready_i; no combinational path from s_valid_i.
- Throughput is 1 pixel/cycle with m_ready_i held high. A frame ending in phase 1 or 2 costs one bubble cycle.
- With m_valid_o=1 and m_ready_i=0, m_data_o, m_keep_o and m_last_o stay stable.
- Reset (any cycle, including mid-frame or mid-flush):
  - m_valid_o, m_data_o, m_keep_o, m_last_o, the phase counter, the residual and flush_pending all clear to 0.
  - s_ready_o is 0 while rst_i=1.
  - A partial frame is discarded; the first pixel after reset is treated as phase 0.
- s_valid_i may drop mid-frame; the phase and residual are held indefinitely.

## Structure
- Shared package uirgb_pkg holds:
  - the phase encoding constants PH0..PH3;
  - the keep constants KEEP_FULL=4'hF, KEEP_3B=4'h7, KEEP_2B=4'h3, KEEP_1B=4'h1;
  - pixel and word width localparams 24 and 32.
- Single flat module; no sub-module is warranted. The datapath is one case on phase plus the output and flush registers.

## Test plan
- 4 pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A (last on 4th), m_ready_i=1 → words 0x04030201, 0x08070605, 0x0C0B0A09; keep F on all; last on 3rd only; no bubbles.
- 1-pixel frame 0x030201 with last → one word 0x00030201, keep 4'h7, last.
- 2-pixel frame 0x030201, 0x060504 → 0x04030201 keep F, then 0x00000605 keep 4'h3 last; s_ready_o=0 for exactly one cycle.
- 3-pixel frame 0x030201, 0x060504, 0x090807 → 0x04030201, 0x08070605, 0x00000009 keep 4'h1 last; with PAD_BYTE=8'hAA the last word is 0xAAAAAA09.
- Random m_ready_i backpressure plus random s_valid_i gaps over a 1920-pixel frame → 1440 words matching the reference model; outputs stable while stalled; last only on word 1440.
- Assert rst_i for one cycle after 2 pixels of a frame and during a pending flush → no further words from the old frame; the next frame 0x030201 (single, last) yields 0x00030201 keep 4'h7.
